// File: rtl/symbol_depacketizer_pkg.sv
// ============================================================================
// symbol_depacketizer_pkg: shared state encodings and header/Barker constants.
// Rev 1.0
// ============================================================================
`default_nettype none

package symbol_depacketizer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned HDR_BITS     = 16;
  localparam int unsigned BD_WAIT_BASE = 31;

  // Symbols still to discard after the Barker window has been observed.
  function automatic int unsigned bd_wait_count(input int unsigned window);
    return (window > BD_WAIT_BASE) ? 0 : (BD_WAIT_BASE - window);
  endfunction

endpackage

`default_nettype wire

// File: rtl/symbol_depacketizer_if.sv
// ============================================================================
// symbol_depacketizer_if: AXI-Stream payload bus with master/slave modports.
// Rev 1.0
// ============================================================================
`default_nettype none

interface symbol_depacketizer_if #(
  parameter int BYTES = 1
);
  logic [BYTES*8-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic               tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

`default_nettype wire

// File: rtl/symbol_depacketizer_sync_fifo.sv
// ============================================================================
// symbol_depacketizer_sync_fifo: show-ahead synchronous FIFO, occupancy-counted.
// Rev 1.0
// ============================================================================
`default_nettype none

module symbol_depacketizer_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             wr_en,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic             rd_en,
  output logic      [WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still accepts a write when a read frees a slot this cycle.
  assign do_wr   = wr_en & (~full | rd_en);
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/symbol_depacketizer.sv
// ============================================================================
// symbol_depacketizer: Barker wait, 16-bit header decode, BPSK/QPSK packing to AXIS.
// Optional macro DEPACK_SGN_CORR_EN enables Barker-sign correction.  Rev 1.0
// ============================================================================
`default_nettype none

module symbol_depacketizer
  import symbol_depacketizer_pkg::*;
#(
  parameter int BYTES            = 1,
  parameter int MAX_WINDOW_WIDTH = 8,
  parameter int LEN_WIDTH        = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
  input  wire logic                        SD_flag,
  input  wire logic                        PD_flag,
  input  wire logic                        BD_flag,
  input  wire logic                        BD_sgn,
  input  wire logic                        in_valid,
  input  wire logic [1:0]                  in_QPSK,
  symbol_depacketizer_if.master            data,
  output logic      [1:0]                  QPSK,
  output logic                             BPSK,
  output logic                             is_bpsk,
  output logic                             disassert_BD,
  output logic                             disassert_PD,
  output logic                             ovf
);

  localparam int W    = BYTES * 8;
  localparam int BCW  = $clog2(W) + 1;
  localparam int HCW  = $clog2(HDR_BITS);
  localparam int FW   = W + 2;

  state_t                      state;
  logic [MAX_WINDOW_WIDTH-1:0] wait_cnt;
  logic [HCW-1:0]              hdr_cnt;
  logic                        hdr_mod;
  logic [LEN_WIDTH-1:0]        len;
  logic [LEN_WIDTH-1:0]        word_cnt;
  logic [BCW-1:0]              bit_cnt;
  logic [W-1:0]                shreg;
  logic                        disassert;

  logic                        start;
  logic [MAX_WINDOW_WIDTH-1:0] wait_load;
  logic [1:0]                  sym_c;
  logic [BCW-1:0]              step;
  logic [W-1:0]                shreg_next;
  logic                        word_done;
  logic                        word_last;
  logic                        push;
  logic                        pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [FW-1:0]               fifo_rd;

  assign start     = BD_flag & PD_flag & SD_flag;
  assign wait_load = MAX_WINDOW_WIDTH'(bd_wait_count(32'(RX_BD_WINDOW)));

`ifdef DEPACK_SGN_CORR_EN
  logic inv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      inv <= 1'b0;
    end else if (state == IDLE && start) begin
      inv <= BD_sgn;
    end
  end

  assign sym_c = in_QPSK ^ {2{inv}};
`else
  logic unused_bd_sgn;

  assign unused_bd_sgn = BD_sgn;
  assign sym_c         = in_QPSK;
`endif

  assign step       = is_bpsk ? BCW'(1) : BCW'(2);
  assign shreg_next = is_bpsk ? {shreg[W-2:0], sym_c[1]} : {shreg[W-3:0], sym_c};
  assign word_done  = ((bit_cnt + step) == BCW'(W));
  assign word_last  = (word_cnt == len);
  // Push lands at the edge closing the completing symbol so tvalid follows next cycle.
  assign push       = (state == PAYLOAD) & SD_flag & in_valid & word_done;
  assign pop        = data.tvalid & data.tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      hdr_cnt   <= '0;
      hdr_mod   <= 1'b0;
      len       <= '0;
      word_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      is_bpsk   <= 1'b0;
      disassert <= 1'b0;
      QPSK      <= 2'b00;
      ovf       <= 1'b0;
    end else begin
      disassert <= 1'b0;
      ovf       <= push & fifo_full & ~pop;
      if (in_valid) QPSK <= sym_c;

      case (state)
        IDLE: begin
          if (start) begin
            wait_cnt <= wait_load;
            hdr_cnt  <= '0;
            state    <= (wait_load == '0) ? HEADER : WAIT;
          end
        end

        WAIT, HEADER, PAYLOAD: begin
          if (!SD_flag) begin
            disassert <= 1'b1;
            state     <= IDLE;
          end else if (in_valid) begin
            if (state == WAIT) begin
              wait_cnt <= wait_cnt - 1'b1;
              if (wait_cnt == MAX_WINDOW_WIDTH'(1)) state <= HEADER;
            end else if (state == HEADER) begin
              // Header is taken uncorrected; only the first bit and the low LEN_WIDTH bits matter.
              if (hdr_cnt == '0) hdr_mod <= in_QPSK[1];
              len     <= LEN_WIDTH'({len, in_QPSK[1]});
              hdr_cnt <= hdr_cnt + 1'b1;
              if (hdr_cnt == HCW'(HDR_BITS - 1)) begin
                is_bpsk  <= hdr_mod;
                word_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= '0;
                state    <= PAYLOAD;
              end
            end else begin
              shreg <= shreg_next;
              if (word_done) begin
                bit_cnt  <= '0;
                word_cnt <= word_cnt + 1'b1;
                if (word_last) begin
                  disassert <= 1'b1;
                  state     <= DONE;
                end
              end else begin
                bit_cnt <= bit_cnt + step;
              end
            end
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign BPSK         = QPSK[1];
  assign disassert_BD = disassert;
  assign disassert_PD = disassert;

  symbol_depacketizer_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_sync_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({is_bpsk, word_last, shreg_next}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign data.tdata  = fifo_rd[W-1:0];
  assign data.tlast  = fifo_rd[W];
  assign data.tuser  = fifo_rd[W+1];
  assign data.tvalid = ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_symbol_depacketizer.sv
// ============================================================================
// tb_symbol_depacketizer: scoreboard bench for symbol_depacketizer frames.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_symbol_depacketizer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] RX_BD_WINDOW;
  logic       SD_flag, PD_flag, BD_flag, BD_sgn;
  logic       in_valid;
  logic [1:0] in_QPSK;
  logic [1:0] QPSK;
  logic       BPSK, is_bpsk, disassert_BD, disassert_PD, ovf;

  symbol_depacketizer_if #(.BYTES(1)) axis ();

  symbol_depacketizer #(
    .BYTES            (1),
    .MAX_WINDOW_WIDTH (8),
    .LEN_WIDTH        (8),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_BD_WINDOW (RX_BD_WINDOW),
    .SD_flag      (SD_flag),
    .PD_flag      (PD_flag),
    .BD_flag      (BD_flag),
    .BD_sgn       (BD_sgn),
    .in_valid     (in_valid),
    .in_QPSK      (in_QPSK),
    .data         (axis.master),
    .QPSK         (QPSK),
    .BPSK         (BPSK),
    .is_bpsk      (is_bpsk),
    .disassert_BD (disassert_BD),
    .disassert_PD (disassert_PD),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

`ifdef DEPACK_SGN_CORR_EN
  localparam logic [7:0] SGN_WORD = 8'hB1;
  localparam logic [1:0] SGN_QPSK = 2'b01;
`else
  localparam logic [7:0] SGN_WORD = 8'h4E;
  localparam logic [1:0] SGN_QPSK = 2'b10;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int pulses = 0;
  int ovfs   = 0;
  logic [9:0] sb [$];

  // Output monitor: every AXIS transfer is matched against the scoreboard.
  always @(negedge clk) begin
    logic [9:0] exp_w;
    if (rst && axis.tvalid && axis.tready) begin
      xfers++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL axis_unexpected: got {tuser,tlast,tdata}=%h, required no transfer",
                 {axis.tuser, axis.tlast, axis.tdata});
      end else begin
        exp_w = sb.pop_front();
        if ({axis.tuser, axis.tlast, axis.tdata} !== exp_w) begin
          errors++;
          $display("FAIL axis_word: got {tuser,tlast,tdata}=%h, required %h",
                   {axis.tuser, axis.tlast, axis.tdata}, exp_w);
        end
      end
    end
    if (rst && disassert_BD) begin
      pulses++;
      checks++;
      if (disassert_PD !== 1'b1) begin
        errors++;
        $display("FAIL disassert_pd: got %b, required 1", disassert_PD);
      end
    end
    if (rst && ovf) ovfs++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_sym(input logic [1:0] s);
    in_valid = 1'b1;
    in_QPSK  = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input int window, input logic sgn);
    SD_flag = 1'b1; PD_flag = 1'b1; BD_flag = 1'b1;
    BD_sgn = sgn; RX_BD_WINDOW = 8'(window);
    @(posedge clk); #1;
    PD_flag = 1'b0; BD_flag = 1'b0;
    for (int i = 0; i < ((window > 31) ? 0 : 31 - window); i++) send_sym(2'b00);
  endtask

  task automatic send_header(input logic [15:0] hdr);
    for (int i = 15; i >= 0; i--) send_sym({hdr[i], 1'b0});
  endtask

  task automatic send_bpsk_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_sym({b[i], 1'b0});
  endtask

  task automatic send_qpsk_byte(input logic [7:0] b);
    for (int i = 3; i >= 0; i--) send_sym(b[2*i +: 2]);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || axis.tvalid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_QPSK = 2'b00;
    SD_flag = 1'b0; PD_flag = 1'b0; BD_flag = 1'b0; BD_sgn = 1'b0;
    RX_BD_WINDOW = 8'd0; axis.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", axis.tvalid); end
    checks++; if (axis.tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h, required 00", axis.tdata); end
    checks++; if ({axis.tlast, axis.tuser} !== 2'b00) begin errors++; $display("FAIL rst_tlast_tuser: got %b, required 00", {axis.tlast, axis.tuser}); end
    checks++; if (QPSK !== 2'b00) begin errors++; $display("FAIL rst_qpsk: got %b, required 00", QPSK); end
    checks++; if ({is_bpsk, disassert_BD, disassert_PD, ovf} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b, required 0000", {is_bpsk, disassert_BD, disassert_PD, ovf}); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_bpsk_frame();
    pulses = 0;
    axis.tready = 1'b1;
    start_frame(29, 1'b0);
    send_header(16'h8001);
    sb.push_back({1'b1, 1'b0, 8'hA5});
    sb.push_back({1'b1, 1'b1, 8'h3C});
    send_bpsk_byte(8'hA5);
    checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== 8'hA5) begin errors++; $display("FAIL bpsk_first_latency: got tvalid=%b tdata=%h, required 1 A5", axis.tvalid, axis.tdata); end
    send_bpsk_byte(8'h3C);
    wait_drain(50);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bpsk_drain: got %0d pending, required 0", sb.size()); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bpsk_disassert: got %0d pulses, required 1", pulses); end
    checks++; if (is_bpsk !== 1'b1) begin errors++; $display("FAIL bpsk_is_bpsk: got %b, required 1", is_bpsk); end
  endtask

  task automatic test_qpsk_frame();
    pulses = 0;
    axis.tready = 1'b1;
    start_frame(29, 1'b0);
    send_header(16'h0000);
    sb.push_back({1'b0, 1'b1, 8'hB1});
    send_sym(2'b10); send_sym(2'b11); send_sym(2'b00); send_sym(2'b01);
    checks++; if (QPSK !== 2'b01 || BPSK !== 1'b0) begin errors++; $display("FAIL qpsk_out: got QPSK=%b BPSK=%b, required 01 0", QPSK, BPSK); end
    wait_drain(50);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL qpsk_drain: got %0d pending, required 0", sb.size()); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL qpsk_disassert: got %0d pulses, required 1", pulses); end
    checks++; if (is_bpsk !== 1'b0) begin errors++; $display("FAIL qpsk_is_bpsk: got %b, required 0", is_bpsk); end
  endtask

  task automatic test_sign_inversion();
    axis.tready = 1'b1;
    start_frame(40, 1'b1);
    send_header(16'h0000);
    sb.push_back({1'b0, 1'b1, SGN_WORD});
    send_qpsk_byte(8'h4E);
    checks++; if (QPSK !== SGN_QPSK) begin errors++; $display("FAIL sgn_qpsk_out: got %b, required %b", QPSK, SGN_QPSK); end
    wait_drain(50);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sgn_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int base;
    pulses = 0; ovfs = 0;
    axis.tready = 1'b0;
    start_frame(31, 1'b0);
    send_header(16'h0005);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) sb.push_back({1'b0, 1'b0, 8'(k * 8'h11)});
      send_qpsk_byte(8'(k * 8'h11));
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ovfs != 2) begin errors++; $display("FAIL bp_ovf: got %0d pulses, required 2", ovfs); end
    checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h11) begin errors++; $display("FAIL bp_hold: got tvalid=%b tdata=%h, required 1 11", axis.tvalid, axis.tdata); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bp_disassert: got %0d pulses, required 1", pulses); end
    base = xfers;
    axis.tready = 1'b1;
    wait_drain(50);
    checks++; if (xfers - base != 4 || sb.size() != 0) begin errors++; $display("FAIL bp_delivered: got %0d words, %0d pending, required 4, 0", xfers - base, sb.size()); end
  endtask

  task automatic test_abort();
    int base;
    pulses = 0;
    base = xfers;
    axis.tready = 1'b1;
    start_frame(30, 1'b0);
    send_header(16'h0001);
    send_sym(2'b11); send_sym(2'b01); send_sym(2'b10);
    SD_flag = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (pulses != 1) begin errors++; $display("FAIL abort_disassert: got %0d pulses, required 1", pulses); end
    checks++; if (xfers != base || axis.tvalid !== 1'b0) begin errors++; $display("FAIL abort_no_output: got %0d words tvalid=%b, required 0 0", xfers - base, axis.tvalid); end
    start_frame(29, 1'b0);
    send_header(16'h0000);
    sb.push_back({1'b0, 1'b1, 8'h5A});
    send_qpsk_byte(8'h5A);
    wait_drain(50);
    checks++; if (sb.size() != 0 || xfers - base != 1) begin errors++; $display("FAIL abort_next_frame: got %0d words %0d pending, required 1 0", xfers - base, sb.size()); end
  endtask

  task automatic test_reset_midframe();
    int base;
    base = xfers;
    axis.tready = 1'b0;
    start_frame(31, 1'b0);
    send_header(16'h0003);
    send_qpsk_byte(8'h12);
    send_qpsk_byte(8'h34);
    checks++; if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h12) begin errors++; $display("FAIL rstmid_queued: got tvalid=%b tdata=%h, required 1 12", axis.tvalid, axis.tdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b, required 0", axis.tvalid); end
    @(posedge clk); #1;
    SD_flag = 1'b0;
    rst = 1'b1;
    axis.tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (xfers != base || axis.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_residual: got %0d words tvalid=%b, required 0 0", xfers - base, axis.tvalid); end
  endtask

  initial begin
    test_reset();
    test_bpsk_frame();
    test_qpsk_frame();
    test_sign_inversion();
    test_backpressure();
    test_abort();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
